// File: rtl/mor1kx_branch_predictor_configurable.sv
// Dynamic branch predictor for l.bf/l.bnf: a PHT of saturating counters indexed
// bimodally or by gshare, cleared by a sweep after reset (static rule until then).
module mor1kx_branch_predictor_configurable #(
  parameter int    OPTION_OPERAND_WIDTH = 32,
  parameter int    PHT_INDEX_WIDTH      = 6,
  parameter int    GHR_WIDTH            = 6,
  parameter int    COUNTER_WIDTH        = 2,
  parameter string PREDICTOR_MODE       = "GSHARE"
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            op_bf_i,
  input  logic                            op_bnf_i,
  input  logic [9:0]                      immjbr_upper_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] brn_pc_i,
  input  logic                            padv_decode_i,
  output logic                            predicted_flag_o,
  input  logic                            prev_op_brcond_i,
  input  logic                            prev_predicted_flag_i,
  input  logic                            execute_bf_i,
  input  logic                            execute_bnf_i,
  input  logic                            flag_i,
  output logic                            branch_mispredict_o,
  output logic                            init_done_o
);

  localparam int PHT_SIZE = 1 << PHT_INDEX_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] CNT_WNT =
    COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);
  localparam bit GSHARE = (PREDICTOR_MODE == "GSHARE");

  if (PREDICTOR_MODE != "GSHARE" && PREDICTOR_MODE != "BIMODAL") begin : g_bad_mode
    $error("mor1kx_branch_predictor_configurable: PREDICTOR_MODE must be GSHARE or BIMODAL");
  end

  typedef enum logic {INIT, RUN} state_t;

  state_t                     state;
  logic [PHT_INDEX_WIDTH-1:0] sweep_ptr;
  logic [PHT_INDEX_WIDTH-1:0] pend_idx;
  logic [PHT_INDEX_WIDTH-1:0] idx;
  logic [PHT_INDEX_WIDTH-1:0] pc_idx;
  logic [GHR_WIDTH-1:0]       ghr;
  logic [GHR_WIDTH-1:0]       ghr_next;
  logic [COUNTER_WIDTH-1:0]   pht [PHT_SIZE];
  logic                       taken;
  logic                       actual_taken;
  logic                       upd;
  logic                       capture;
  logic                       unused_bits;

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [COUNTER_WIDTH-1:0] sat_dec(input logic [COUNTER_WIDTH-1:0] c);
    return (|c) ? c - 1'b1 : c;
  endfunction

  assign unused_bits = ^{brn_pc_i[OPTION_OPERAND_WIDTH-1:PHT_INDEX_WIDTH+2], brn_pc_i[1:0],
                         immjbr_upper_i[8:0], execute_bnf_i};

  // Decode: index, prediction and capture of the branch going down the pipe
  assign pc_idx  = brn_pc_i[PHT_INDEX_WIDTH+1:2];
  assign idx     = GSHARE ? (pc_idx ^ PHT_INDEX_WIDTH'(ghr)) : pc_idx;
  assign taken   = init_done_o ? pht[idx][COUNTER_WIDTH-1] : immjbr_upper_i[9];
  assign capture = padv_decode_i & (op_bf_i | op_bnf_i);

  assign predicted_flag_o = (op_bf_i & taken) | (op_bnf_i & ~taken);

  // Resolution: compare against the real flag and train non-speculatively
  assign branch_mispredict_o = prev_op_brcond_i & (flag_i != prev_predicted_flag_i);
  assign upd                 = prev_op_brcond_i & padv_decode_i & init_done_o;
  assign actual_taken        = execute_bf_i ? flag_i : ~flag_i;

  if (GHR_WIDTH == 1) begin : g_ghr1
    assign ghr_next = actual_taken;
  end else begin : g_ghrn
    assign ghr_next = {ghr[GHR_WIDTH-2:0], actual_taken};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      sweep_ptr   <= '0;
      init_done_o <= 1'b0;
      ghr         <= '0;
      pend_idx    <= '0;
    end else begin
      case (state)
        INIT: begin
          sweep_ptr <= sweep_ptr + 1'b1;
          if (&sweep_ptr) begin
            state       <= RUN;
            init_done_o <= 1'b1;
          end
        end
        default: ;
      endcase
      if (upd)
        ghr <= ghr_next;
      if (capture)
        pend_idx <= idx;
    end
  end

  // Counter table: sweep clear while initialising, saturating training afterwards
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)
        pht[sweep_ptr] <= CNT_WNT;
      else if (upd)
        pht[pend_idx] <= actual_taken ? sat_inc(pht[pend_idx]) : sat_dec(pht[pend_idx]);
    end
  end

endmodule

// File: tb/tb_mor1kx_branch_predictor_configurable.sv
// Scoreboard bench: a GSHARE and a BIMODAL instance share stimulus and are
// checked against a table-level model of the predictor.
module tb_mor1kx_branch_predictor_configurable;

  logic        clk;
  logic        rst;
  logic        op_bf, op_bnf, padv, prev_brcond, prev_pred, ex_bf, ex_bnf, flag;
  logic [9:0]  imm_upper;
  logic [31:0] pc;
  logic        pred_g, misp_g, done_g;
  logic        pred_b, misp_b, done_b;

  mor1kx_branch_predictor_configurable #(.PREDICTOR_MODE("GSHARE")) dut_g (
    .clk(clk), .rst(rst), .op_bf_i(op_bf), .op_bnf_i(op_bnf),
    .immjbr_upper_i(imm_upper), .brn_pc_i(pc), .padv_decode_i(padv),
    .predicted_flag_o(pred_g), .prev_op_brcond_i(prev_brcond),
    .prev_predicted_flag_i(prev_pred), .execute_bf_i(ex_bf), .execute_bnf_i(ex_bnf),
    .flag_i(flag), .branch_mispredict_o(misp_g), .init_done_o(done_g));

  mor1kx_branch_predictor_configurable #(.PREDICTOR_MODE("BIMODAL")) dut_b (
    .clk(clk), .rst(rst), .op_bf_i(op_bf), .op_bnf_i(op_bnf),
    .immjbr_upper_i(imm_upper), .brn_pc_i(pc), .padv_decode_i(padv),
    .predicted_flag_o(pred_b), .prev_op_brcond_i(prev_brcond),
    .prev_predicted_flag_i(prev_pred), .execute_bf_i(ex_bf), .execute_bnf_i(ex_bnf),
    .flag_i(flag), .branch_mispredict_o(misp_b), .init_done_o(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit pred_g;
    bit pred_b;
    bit misp;
    bit done;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   misp_cnt = 0;

  // Reference model: counters as integers 0..3, history as an integer
  int pht_g[64];
  int pht_b[64];
  int ghr, pend_g, pend_b, cyc;
  bit done;
  bit last_pred_g;

  task automatic cmp(input string nm, input logic act, input bit expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s actual=%0b required=%0b at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("pred_gshare", pred_g, e.pred_g);
      cmp("pred_bimodal", pred_b, e.pred_b);
      cmp("mispredict_gshare", misp_g, e.misp);
      cmp("mispredict_bimodal", misp_b, e.misp);
      cmp("init_done_gshare", done_g, e.done);
      cmp("init_done_bimodal", done_b, e.done);
      if (misp_g === 1'b1) misp_cnt++;
    end
  end

  task automatic step(input bit r, input bit bf, input bit bnf, input bit imm9,
                      input logic [31:0] pcv, input bit pa, input bit pbr,
                      input bit ppred, input bit ebf, input bit flg, input bit chk_en);
    exp_t e;
    int   ig, ib;
    bit   tg, tb, at;
    @(posedge clk);
    #1;
    rst = r; op_bf = bf; op_bnf = bnf; imm_upper = {imm9, 9'(($urandom))};
    pc = pcv; padv = pa; prev_brcond = pbr; prev_pred = ppred;
    ex_bf = ebf; ex_bnf = ~ebf; flag = flg;
    ib = int'((pcv >> 2) & 32'd63);
    ig = ib ^ ghr;
    tg = done ? (pht_g[ig] >= 2) : imm9;
    tb = done ? (pht_b[ib] >= 2) : imm9;
    e.pred_g = (bf & tg) | (bnf & ~tg);
    e.pred_b = (bf & tb) | (bnf & ~tb);
    e.misp   = pbr & (flg != ppred);
    e.done   = done;
    last_pred_g = e.pred_g;
    if (chk_en) q.push_back(e);
    if (r) begin
      ghr = 0; pend_g = 0; pend_b = 0; cyc = 0; done = 0;
    end else begin
      if (pbr && pa && done) begin
        at = ebf ? flg : ~flg;
        if (at) begin
          if (pht_g[pend_g] < 3) pht_g[pend_g]++;
          if (pht_b[pend_b] < 3) pht_b[pend_b]++;
        end else begin
          if (pht_g[pend_g] > 0) pht_g[pend_g]--;
          if (pht_b[pend_b] > 0) pht_b[pend_b]--;
        end
        ghr = ((ghr << 1) | int'(at)) & 63;
      end
      if (pa && (bf || bnf)) begin
        pend_g = ig;
        pend_b = ib;
      end
      if (!done) begin
        cyc++;
        if (cyc == 64) begin
          done = 1;
          for (int i = 0; i < 64; i++) begin
            pht_g[i] = 1;
            pht_b[i] = 1;
          end
        end
      end
    end
  endtask

  task automatic rand_step();
    step(0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom),
         1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
  endtask

  // Decode a branch, then resolve it next cycle with the model's prediction
  task automatic branch(input logic [31:0] pcv, input bit is_bf, input bit flg);
    bit p;
    step(0, is_bf, ~is_bf, 1'($urandom), pcv, 1, 0, 0, 0, 0, 1);
    p = last_pred_g;
    step(0, 0, 0, 0, pcv, 1, 1, p, is_bf, flg, 1);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 70 && !done; i++) rand_step();
  endtask

  initial begin
    int misp_before;
    int rise;
    rst = 1; op_bf = 0; op_bnf = 0; imm_upper = '0; pc = '0; padv = 0;
    prev_brcond = 0; prev_pred = 0; ex_bf = 0; ex_bnf = 0; flag = 0;
    ghr = 0; pend_g = 0; pend_b = 0; cyc = 0; done = 0;
    step(1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);

    // Sweep phase: static backward-taken rule, updates ignored
    step(0, 1, 0, 1, 32'h200, 1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 32'h200, 1, 0, 0, 0, 0, 1);
    wait_done();

    // Every counter starts weakly not-taken
    for (int i = 0; i < 64; i++) step(0, 1, 0, 1, 32'(i << 2), 0, 0, 0, 0, 0, 1);

    // Bimodal training at PC 0x100: saturate up, then walk down
    for (int i = 0; i < 3; i++) branch(32'h100, 1, 1);
    branch(32'h100, 1, 0);
    branch(32'h100, 1, 0);
    branch(32'h100, 1, 1);

    // l.bnf resolved with flag=1
    for (int i = 0; i < 4; i++) branch(32'h340, 0, 1);

    // Gshare on an alternating branch converges to no mispredicts
    do_reset();
    wait_done();
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        @(negedge clk);
        #1 misp_before = misp_cnt;
      end
      branch(32'h100, 1, (i % 2) == 0);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (misp_cnt - misp_before != 0) begin
      n_fail++;
      $display("FAIL gshare_alternating_converged actual=%0d required=0", misp_cnt - misp_before);
    end

    // Random traffic with overlapping capture and update
    for (int i = 0; i < 600; i++) rand_step();

    // Reset in the middle of a sweep restarts it
    do_reset();
    for (int i = 0; i < 20; i++) rand_step();
    do_reset();
    rise = -1;
    for (int k = 0; k < 80; k++) begin
      rand_step();
      if (rise < 0 && done_g === 1'b1) rise = k;
    end
    n_cmp++;
    if (rise != 64) begin
      n_fail++;
      $display("FAIL init_done_rise_after_midsweep_reset actual=%0d required=64", rise);
    end
    for (int i = 0; i < 200; i++) rand_step();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
